// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: state codes,
// opcode/funct3 constants, datapath mux selects and ALU control classes.
package multi_cycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_LUI       = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_ITYPE = 3'd3;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Only BEQ and BNE are implemented; every other branch funct3 traps.
    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; flags expiry in the last allowed cycle so
// the FSM can trap instead of waiting forever on a dead memory.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

    logic [CW-1:0] cnt;

    // Count stalled cycles; any cycle without a request or with a completed
    // transfer restarts the count, so each memory state starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!req || ready)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // cnt holds the number of earlier stalled cycles, so the WAIT_LIMIT-th
    // stalled cycle is the one where cnt == WAIT_LIMIT-1; ready still wins.
    assign expired = req && !ready && (cnt == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of a multi-cycle RV32 subset core. State, sticky flags and
// the retire counter are registered; datapath controls decode from the state
// (plus ready/zero where a strobe depends on them) and are forced low in reset.
module multi_cycle_control
    import multi_cycle_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        i_or_d_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic [1:0]  mem_to_reg_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [31:0] retired_o
);

    state_t state;
    logic   expired;

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .req     (mem_req_o),
        .ready   (mem_ready_i),
        .expired (expired)
    );

    assign state_o = state;

    // Next-state sequencing, sticky trap flags and retired-instruction count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            illegal_o <= 1'b0;
            timeout_o <= 1'b0;
            retired_o <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready_i) state <= S_DECODE;
                    else if (expired) begin
                        state     <= S_TRAP;
                        timeout_o <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (op_i)
                        OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
                        OP_RTYPE:          state <= S_EXEC_R;
                        OP_ITYPE:          state <= S_EXEC_I;
                        OP_JAL:            state <= S_JAL;
                        OP_LUI:            state <= S_LUI;
                        OP_BRANCH: begin
                            if (branch_f3_ok(funct3_i)) state <= S_BRANCH;
                            else begin
                                state     <= S_TRAP;
                                illegal_o <= 1'b1;
                            end
                        end
                        default: begin
                            state     <= S_TRAP;
                            illegal_o <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: state <= (op_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: begin
                    if (mem_ready_i) state <= S_MEM_WB;
                    else if (expired) begin
                        state     <= S_TRAP;
                        timeout_o <= 1'b1;
                    end
                end
                S_MEM_WRITE: begin
                    if (mem_ready_i) begin
                        state     <= S_FETCH;
                        retired_o <= retired_o + 32'd1;
                    end else if (expired) begin
                        state     <= S_TRAP;
                        timeout_o <= 1'b1;
                    end
                end
                S_EXEC_R, S_EXEC_I, S_LUI: state <= S_ALU_WB;
                S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: begin
                    state     <= S_FETCH;
                    retired_o <= retired_o + 32'd1;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Per-state datapath controls; everything idles at zero while in reset.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        i_or_d_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = WB_ALUOUT;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = ALU_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                    alu_src_a_o = SRC_A_PC;
                    alu_src_b_o = SRC_B_FOUR;
                end
                S_DECODE: begin
                    alu_src_a_o = SRC_A_OLDPC;
                    alu_src_b_o = SRC_B_IMM;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = SRC_A_RS1;
                    alu_src_b_o = SRC_B_IMM;
                end
                S_MEM_READ: begin
                    mem_req_o = 1'b1;
                    i_or_d_o  = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    i_or_d_o  = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = WB_MDR;
                end
                S_EXEC_R: begin
                    alu_src_a_o = SRC_A_RS1;
                    alu_src_b_o = SRC_B_RS2;
                    alu_op_o    = ALU_RTYPE;
                end
                S_EXEC_I: begin
                    alu_src_a_o = SRC_A_RS1;
                    alu_src_b_o = SRC_B_IMM;
                    alu_op_o    = ALU_ITYPE;
                end
                S_LUI: begin
                    alu_src_a_o = SRC_A_ZERO;
                    alu_src_b_o = SRC_B_IMM;
                end
                S_ALU_WB: reg_write_o = 1'b1;
                S_BRANCH: begin
                    alu_src_a_o = SRC_A_RS1;
                    alu_src_b_o = SRC_B_RS2;
                    alu_op_o    = ALU_SUB;
                    pc_src_o    = 1'b1;
                    pc_write_o  = branch_taken(funct3_i, zero_i);
                end
                S_JAL: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = WB_PC;
                    pc_write_o   = 1'b1;
                    pc_src_o     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum memory wait cycles before a timeout trap.
REQ-002 SHALL have ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_i  in  7  instruction register bits [6:0].
- funct3_i  in  3  instruction register bits [14:12].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the access this cycle.
- mem_req_o  out  1  memory access request.
- mem_we_o  out  1  write strobe, valid with mem_req_o.
- i_or_d_o  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load instruction register.
- pc_write_o  out  1  load PC.
- pc_src_o  out  1  next-PC select: 0 = ALU result, 1 = ALUOut.
- reg_write_o  out  1  register file write enable.
- mem_to_reg_o  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC.
- alu_src_a_o  out  2  ALU A select: 0 = PC, 1 = oldPC, 2 = rs1, 3 = zero.
- alu_src_b_o  out  2  ALU B select: 0 = rs2, 1 = constant 4, 2 = immediate.
- alu_op_o  out  3  ALU control class: 0 = ADD, 1 = SUB, 2 = R-type, 3 = I-type.
- state_o  out  4  current state encoding.
- illegal_o  out  1  sticky flag: illegal opcode or funct3.
- timeout_o  out  1  sticky flag: memory wait timeout.
- retired_o  out  32  retired-instruction count.

Function
REQ-003 SHALL implement the states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.
REQ-004 FETCH SHALL assert mem_req_o with i_or_d_o=0, hold the state until mem_ready_i, and in the ready cycle assert ir_write_o and pc_write_o with src_a=PC, src_b=4, ADD, pc_src=0, then go to DECODE.
REQ-005 DECODE SHALL drive src_a=oldPC, src_b=imm, ADD, and branch on op_i: 0000011/0100011 to MEM_ADDR, 0110011 to EXEC_R, 0010011 to EXEC_I, 1100011 to BRANCH, 1101111 to JAL, 0110111 to LUI.
REQ-006 DECODE SHALL go to TRAP and set illegal_o for any other opcode, or for a branch whose funct3 is not 000 or 001.
REQ-007 MEM_ADDR SHALL drive src_a=rs1, src_b=imm, ADD, then go to MEM_READ for a load or MEM_WRITE for a store.
REQ-008 MEM_READ SHALL assert mem_req_o with i_or_d_o=1 and go to MEM_WB on ready.
REQ-009 MEM_WRITE SHALL assert mem_req_o and mem_we_o with i_or_d_o=1 and go to FETCH on ready.
REQ-010 MEM_WB SHALL assert reg_write_o with mem_to_reg=1, then go to FETCH.
REQ-011 EXEC_R (rs1/rs2, R-type) and EXEC_I (rs1/imm, I-type) SHALL go to ALU_WB; LUI (zero/imm, ADD) SHALL go to ALU_WB.
REQ-012 ALU_WB SHALL assert reg_write_o with mem_to_reg=0, then go to FETCH.
REQ-013 BRANCH SHALL drive rs1/rs2, SUB, pc_src=1, and pc_write_o = (funct3=000 & zero_i) | (funct3=001 & !zero_i) combinationally, then go to FETCH.
REQ-014 JAL SHALL assert reg_write_o with mem_to_reg=2, pc_write_o and pc_src=1, then go to FETCH.
REQ-015 Handshake: once asserted, mem_req_o, mem_we_o and i_or_d_o SHALL stay stable until the cycle in which mem_req_o and mem_ready_i are both high; a transfer SHALL complete only in that cycle.
REQ-016 The wait counter SHALL clear on entry to each memory state and count cycles with mem_req_o high and mem_ready_i low; when it reaches WAIT_LIMIT without ready, the block SHALL go to TRAP and set timeout_o.
REQ-017 mem_ready_i arriving in the limit cycle SHALL win: the transfer completes and no timeout is raised.
REQ-018 TRAP SHALL hold all strobes low and be left only by reset.
REQ-019 retired_o SHALL increment by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH or JAL, and wrap modulo 2^32.
REQ-020 Strobes not listed for a state SHALL be 0; mux selects not listed SHALL be 0.

Reset
REQ-021 On reset assertion, at any time including mid-access, the block SHALL go immediately to FETCH and clear the counters, illegal_o and timeout_o.
REQ-022 While reset is high, all strobes SHALL be 0, including mem_req_o.
REQ-023 mem_req_o SHALL assert in the first cycle after reset deasserts.

Structure
REQ-024 State encodings, opcode constants, mux-select encodings and alu_op codes SHALL live in the shared package multi_cycle_pkg.
REQ-025 The wait counter and timeout compare SHALL be the sub-module mem_wait_timer.

Verification
REQ-026 addi x1,x0,5 (0x00500093) with ready=1 on first request -> states 0,1,7,8,0; reg_write_o in ALU_WB; retired_o=1.
REQ-027 lw with ready delayed 3 cycles -> MEM_READ held 4 cycles; mem_req_o and i_or_d_o stable throughout; then MEM_WB.
REQ-028 beq with zero_i=1 -> pc_write_o=1 and pc_src_o=1 in BRANCH; with zero_i=0 -> pc_write_o=0.
REQ-029 opcode 0x7F -> TRAP; illegal_o=1; strobes stay 0 for 10 or more cycles.
REQ-030 FETCH with ready never asserted, WAIT_LIMIT=15 -> TRAP after 15 cycles; timeout_o=1; ready in cycle 15 instead -> DECODE with no timeout.
REQ-031 reset pulsed during MEM_WRITE wait -> mem_we_o drops immediately; retired_o=0; FETCH requests on the first post-reset cycle.
